dm_access_ctrl: RTL and testbench

Multi-cycle data-memory access sequencer between the M stage and a data-memory/bridge port with a req/ack handshake.
- Checks alignment of each load or store and raises an address exception instead of accessing the bus.
- Generates byte enables and replicated store data, and stalls the pipeline while an access is outstanding.
- Returns sign- or zero-extended load data in a single Done cycle.
- Bus timeouts and bus errors are reported as a bus-error pulse.

---
 rtl/dm_pkg.sv | 25 ++
 rtl/dm_store_align.sv | 47 ++++
 rtl/dm_access_ctrl.sv | 178 +++++++++++++++++
 tb/tb_dm_access_ctrl.sv | 262 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/dm_pkg.sv
// ---------------------------------------------------------------------------
// dm_pkg
// Shared definitions for the data-memory access sequencer:
//   - access width codes as presented on M_Width
//   - FSM state encoding for dm_access_ctrl
//   - eff_width(): folds the illegal width code 3 onto word
// ---------------------------------------------------------------------------
package dm_pkg;

    localparam logic [1:0] WIDTH_WORD = 2'd0;
    localparam logic [1:0] WIDTH_HALF = 2'd1;
    localparam logic [1:0] WIDTH_BYTE = 2'd2;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_REQ  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    // Width code 3 is illegal and behaves exactly like a word access.
    function automatic logic [1:0] eff_width(input logic [1:0] width);
        return (width == 2'd3) ? WIDTH_WORD : width;
    endfunction

endpackage

// File: rtl/dm_store_align.sv
// ---------------------------------------------------------------------------
// dm_store_align
// Combinational store lane steering: turns a right-aligned store operand into
// per-lane byte enables and replicated write data for a 32-bit bus.
// Ports:
//   i_addr_lo  in  2   byte offset within the word (Addr[1:0])
//   i_width    in  2   access width code (3 treated as word)
//   i_wd       in  32  right-aligned store data
//   o_be       out 4   byte enables for a store of this width/offset
//   o_wd       out 32  store data replicated across all lanes
// ---------------------------------------------------------------------------
module dm_store_align
    import dm_pkg::*;
(
    input  logic [1:0]  i_addr_lo,
    input  logic [1:0]  i_width,
    input  logic [31:0] i_wd,
    output logic [3:0]  o_be,
    output logic [31:0] o_wd
);

    logic [1:0] w_width;
    logic       w_is_byte;
    logic       w_is_half;

    assign w_width   = eff_width(i_width);
    assign w_is_byte = (w_width == WIDTH_BYTE);
    assign w_is_half = (w_width == WIDTH_HALF);

    // Each lane decides independently: a byte store lights only the addressed
    // lane, a half store lights the addressed halfword, a word lights all.
    genvar gi;
    generate
        for (gi = 0; gi < 4; gi++) begin : g_lane
            localparam logic [1:0] LANE = 2'(gi);

            assign o_be[gi] = w_is_byte ? (i_addr_lo == LANE)
                            : w_is_half ? (i_addr_lo[1] == LANE[1])
                            : 1'b1;

            assign o_wd[8*gi +: 8] = w_is_byte ? i_wd[7:0]
                                   : w_is_half ? i_wd[8*(gi%2) +: 8]
                                   : i_wd[8*gi +: 8];
        end
    endgenerate

endmodule

// File: rtl/dm_access_ctrl.sv
// ---------------------------------------------------------------------------
// dm_access_ctrl
// Multi-cycle data-memory access sequencer between the M stage and a
// req/ack data-memory/bridge port. Misaligned accesses raise an address
// exception without touching the bus; aligned ones stall the pipeline until
// the bus acks (or times out) and complete with a single M_Done pulse.
// Ports:
//   clk, reset            clock; synchronous active-low reset
//   M_Req/M_WE/M_Width/M_Unsigned/M_Addr/M_WD   M-stage request
//   M_Stall               pipeline freeze
//   M_Done/M_RD/M_BusErr  completion pulse, extended load data, bus error
//   M_AdEL/M_AdES         misaligned load / store exception
//   bus_req/bus_we/bus_addr/bus_be/bus_wd       bus request side
//   bus_ack/bus_rd/bus_err                      bus response side
// ---------------------------------------------------------------------------
module dm_access_ctrl
    import dm_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 16,
    parameter int CNT_W          = 5
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        M_Req,
    input  logic        M_WE,
    input  logic [1:0]  M_Width,
    input  logic        M_Unsigned,
    input  logic [31:0] M_Addr,
    input  logic [31:0] M_WD,
    output logic        M_Stall,
    output logic        M_Done,
    output logic [31:0] M_RD,
    output logic        M_AdEL,
    output logic        M_AdES,
    output logic        M_BusErr,
    output logic        bus_req,
    output logic        bus_we,
    output logic [31:0] bus_addr,
    output logic [3:0]  bus_be,
    output logic [31:0] bus_wd,
    input  logic        bus_ack,
    input  logic [31:0] bus_rd,
    input  logic        bus_err
);

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

    state_t            r_state;
    logic [CNT_W-1:0]  r_cnt;
    logic [1:0]        r_addr_lo;
    logic [1:0]        r_width;
    logic              r_unsigned;
    logic [31:0]       r_rdata;
    logic              r_err;
    logic              r_done;
    logic              r_bus_req;
    logic              r_bus_we;
    logic [31:0]       r_bus_addr;
    logic [3:0]        r_bus_be;
    logic [31:0]       r_bus_wd;

    logic [1:0]        w_width;
    logic              w_misaligned;
    logic              w_idle_req;
    logic              w_launch;
    logic [3:0]        w_be;
    logic [31:0]       w_wd;
    logic [7:0]        w_lane_b;
    logic [15:0]       w_lane_h;
    logic [31:0]       w_load_data;

    assign w_width      = eff_width(M_Width);
    assign w_misaligned = ((w_width == WIDTH_HALF) && M_Addr[0]) ||
                          ((w_width == WIDTH_WORD) && (M_Addr[1:0] != 2'b00));

    // Requests are only considered in IDLE and never while reset is held,
    // so a request presented during reset neither stalls nor traps.
    assign w_idle_req = reset && (r_state == ST_IDLE) && M_Req;
    assign w_launch   = w_idle_req && !w_misaligned;

    assign M_AdEL  = w_idle_req && w_misaligned && !M_WE;
    assign M_AdES  = w_idle_req && w_misaligned &&  M_WE;
    assign M_Stall = w_launch || (r_state == ST_REQ);

    dm_store_align u_store_align (
        .i_addr_lo (M_Addr[1:0]),
        .i_width   (M_Width),
        .i_wd      (M_WD),
        .o_be      (w_be),
        .o_wd      (w_wd)
    );

    // Load lane selection uses the offset captured at launch, not the live
    // M_Addr, since the bus response arrives cycles later.
    assign w_lane_b = bus_rd[{r_addr_lo, 3'b000} +: 8];
    assign w_lane_h = r_addr_lo[1] ? bus_rd[31:16] : bus_rd[15:0];

    always_comb begin
        w_load_data = bus_rd;
        case (r_width)
            WIDTH_BYTE: w_load_data = {{24{~r_unsigned & w_lane_b[7]}}, w_lane_b};
            WIDTH_HALF: w_load_data = {{16{~r_unsigned & w_lane_h[15]}}, w_lane_h};
            default:    w_load_data = bus_rd;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            r_state    <= ST_IDLE;
            r_cnt      <= '0;
            r_addr_lo  <= 2'b00;
            r_width    <= WIDTH_WORD;
            r_unsigned <= 1'b0;
            r_rdata    <= 32'd0;
            r_err      <= 1'b0;
            r_done     <= 1'b0;
            r_bus_req  <= 1'b0;
            r_bus_we   <= 1'b0;
            r_bus_addr <= 32'd0;
            r_bus_be   <= 4'd0;
            r_bus_wd   <= 32'd0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (w_launch) begin
                        r_state    <= ST_REQ;
                        r_cnt      <= '0;
                        r_bus_req  <= 1'b1;
                        r_bus_we   <= M_WE;
                        r_bus_addr <= {M_Addr[31:2], 2'b00};
                        r_bus_be   <= M_WE ? w_be : 4'b0000;
                        r_bus_wd   <= w_wd;
                        r_width    <= w_width;
                        r_unsigned <= M_Unsigned;
                        r_addr_lo  <= M_Addr[1:0];
                    end
                end
                ST_REQ: begin
                    if (bus_ack) begin
                        r_state   <= ST_DONE;
                        r_bus_req <= 1'b0;
                        r_done    <= 1'b1;
                        r_rdata   <= r_bus_we ? 32'd0 : w_load_data;
                        r_err     <= bus_err;
                    end else if (r_cnt == CNT_LAST) begin
                        // Ack never came: abort as a bus error with no data.
                        r_state   <= ST_DONE;
                        r_bus_req <= 1'b0;
                        r_done    <= 1'b1;
                        r_rdata   <= 32'd0;
                        r_err     <= 1'b1;
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                ST_DONE: begin
                    // Unconditional return: an M_Req still high here belongs
                    // to the instruction that just completed.
                    r_state <= ST_IDLE;
                    r_done  <= 1'b0;
                    r_rdata <= 32'd0;
                    r_err   <= 1'b0;
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    assign M_Done   = r_done;
    assign M_RD     = r_rdata;
    assign M_BusErr = r_err;
    assign bus_req  = r_bus_req;
    assign bus_we   = r_bus_we;
    assign bus_addr = r_bus_addr;
    assign bus_be   = r_bus_be;
    assign bus_wd   = r_bus_wd;

endmodule

// File: tb/tb_dm_access_ctrl.sv
// ---------------------------------------------------------------------------
// tb_dm_access_ctrl
// Self-checking bench for dm_access_ctrl: directed accesses followed by a
// randomized run, each checked against a size/offset-based reference model.
// ---------------------------------------------------------------------------
module tb_dm_access_ctrl;

    localparam int TO = 16;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        M_Req = 1'b0;
    logic        M_WE = 1'b0;
    logic [1:0]  M_Width = 2'd0;
    logic        M_Unsigned = 1'b0;
    logic [31:0] M_Addr = 32'd0;
    logic [31:0] M_WD = 32'd0;
    logic        M_Stall;
    logic        M_Done;
    logic [31:0] M_RD;
    logic        M_AdEL;
    logic        M_AdES;
    logic        M_BusErr;
    logic        bus_req;
    logic        bus_we;
    logic [31:0] bus_addr;
    logic [3:0]  bus_be;
    logic [31:0] bus_wd;
    logic        bus_ack = 1'b0;
    logic [31:0] bus_rd = 32'd0;
    logic        bus_err = 1'b0;

    dm_access_ctrl #(.TIMEOUT_CYCLES(TO), .CNT_W(5)) dut (
        .clk        (clk),
        .reset      (reset),
        .M_Req      (M_Req),
        .M_WE       (M_WE),
        .M_Width    (M_Width),
        .M_Unsigned (M_Unsigned),
        .M_Addr     (M_Addr),
        .M_WD       (M_WD),
        .M_Stall    (M_Stall),
        .M_Done     (M_Done),
        .M_RD       (M_RD),
        .M_AdEL     (M_AdEL),
        .M_AdES     (M_AdES),
        .M_BusErr   (M_BusErr),
        .bus_req    (bus_req),
        .bus_we     (bus_we),
        .bus_addr   (bus_addr),
        .bus_be     (bus_be),
        .bus_wd     (bus_wd),
        .bus_ack    (bus_ack),
        .bus_rd     (bus_rd),
        .bus_err    (bus_err)
    );

    always #5 clk = ~clk;

    int    n_pass = 0;
    int    n_total = 0;
    int    n_fail = 0;
    string cur = "init";

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s/%s observed=%h expected=%h", cur, tag, obs, exp);
        end
    endtask

    // ---------------- reference model ----------------
    function automatic int nbytes(input logic [1:0] w);
        case (w)
            2'd2:    return 1;
            2'd1:    return 2;
            default: return 4;
        endcase
    endfunction

    // An access is aligned when its address is a multiple of its size.
    function automatic bit is_mis(input logic [1:0] w, input logic [31:0] a);
        return (a % nbytes(w)) != 0;
    endfunction

    function automatic int lane_off(input logic [1:0] w, input logic [31:0] a);
        int n = nbytes(w);
        return ((a % 4) / n) * n;
    endfunction

    function automatic logic [3:0] exp_be(input bit we, input logic [1:0] w, input logic [31:0] a);
        int n = nbytes(w);
        if (!we) return 4'd0;
        return 4'(((1 << n) - 1) << lane_off(w, a));
    endfunction

    function automatic logic [31:0] exp_wd(input logic [1:0] w, input logic [31:0] d);
        case (nbytes(w))
            1:       return d[7:0] * 32'h0101_0101;
            2:       return d[15:0] * 32'h0001_0001;
            default: return d;
        endcase
    endfunction

    function automatic logic [31:0] exp_load(input logic [1:0] w, input bit uns,
                                             input logic [31:0] a, input logic [31:0] rd);
        int          bits = 8 * nbytes(w);
        logic [63:0] mask = (64'd1 << bits) - 64'd1;
        logic [63:0] v    = ({32'd0, rd} >> (8 * lane_off(w, a))) & mask;
        if (!uns && v[bits-1]) v = v | ~mask;
        return v[31:0];
    endfunction

    // ---------------- transaction driver ----------------
    // ack_at: index of the REQ cycle in which bus_ack is raised; -1 = never.
    task automatic access(input string name, input bit we, input logic [1:0] w, input bit uns,
                          input logic [31:0] a, input logic [31:0] d, input int ack_at,
                          input logic [31:0] rd, input bit err);
        bit          mis;
        int          n_req;
        int          guard;
        bit          done;
        logic [31:0] e_rd;
        logic        e_err;
        cur   = name;
        mis   = is_mis(w, a);
        n_req = 0;
        guard = 0;
        done  = 0;
        e_err = (ack_at < 0) ? 1'b1 : err;
        e_rd  = (we || ack_at < 0) ? 32'd0 : exp_load(w, uns, a, rd);

        @(posedge clk); #1;
        M_Req = 1'b1; M_WE = we; M_Width = w; M_Unsigned = uns; M_Addr = a; M_WD = d;
        @(negedge clk);
        chk("AdEL", 32'(mis && !we), 32'(M_AdEL));
        chk("AdES", 32'(M_AdES), 32'(mis && we));
        chk("stall0", 32'(M_Stall), 32'(!mis));
        if (mis) begin
            @(posedge clk); #1;
            M_Req = 1'b0;
            @(negedge clk);
            chk("mis_req", 32'(bus_req), 32'd0);
            chk("mis_done", 32'(M_Done), 32'd0);
            $display("txn %s we=%0d w=%0d addr=%h -> exception", name, we, w, a);
            return;
        end

        while (!done && guard < 60) begin
            @(posedge clk); #1;
            bus_ack = 1'b0;
            guard++;
            if (M_Done) done = 1;
            else begin
                if (n_req == ack_at) begin
                    bus_ack = 1'b1; bus_rd = rd; bus_err = err;
                end else begin
                    bus_rd = $urandom; bus_err = 1'($urandom);
                end
                n_req++;
                @(negedge clk);
                chk("req", 32'(bus_req), 32'd1);
                chk("stall", 32'(M_Stall), 32'd1);
                chk("addr", bus_addr, a & ~32'd3);
                chk("be", 32'(bus_be), 32'(exp_be(we, w, a)));
                chk("wd", bus_wd, exp_wd(w, d));
                chk("we", 32'(bus_we), 32'(we));
            end
        end
        chk("done_seen", 32'(done), 32'd1);
        @(negedge clk);
        chk("req_cycles", n_req, (ack_at < 0) ? TO : ack_at + 1);
        chk("done", 32'(M_Done), 32'd1);
        chk("stall_done", 32'(M_Stall), 32'd0);
        chk("req_done", 32'(bus_req), 32'd0);
        chk("rd", M_RD, e_rd);
        chk("buserr", 32'(M_BusErr), 32'(e_err));
        M_Req = 1'b0;
        @(posedge clk); #1;
        @(negedge clk);
        chk("done_clr", 32'(M_Done), 32'd0);
        chk("rd_clr", M_RD, 32'd0);
        chk("no_relaunch", 32'(bus_req), 32'd0);
        $display("txn %s we=%0d w=%0d addr=%h rd=%h err=%0d req_cycles=%0d", name, we, w, a, M_RD, e_err, n_req);
    endtask

    initial begin
        #300000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        // Reset state
        repeat (3) @(posedge clk);
        @(negedge clk);
        cur = "reset";
        chk("done", 32'(M_Done), 32'd0);
        chk("rd", M_RD, 32'd0);
        chk("buserr", 32'(M_BusErr), 32'd0);
        chk("req", 32'(bus_req), 32'd0);
        chk("stall", 32'(M_Stall), 32'd0);
        chk("addr", bus_addr, 32'd0);
        chk("be", 32'(bus_be), 32'd0);
        chk("wd", bus_wd, 32'd0);
        $display("txn reset checked");
        reset = 1'b1;

        // Directed cases
        access("word_ld",   0, 2'd0, 0, 32'h104, 32'h0,        2, 32'h8000_00F0, 0);
        access("byte_st",   1, 2'd2, 0, 32'h203, 32'h0000_00AB, 0, 32'hDEAD_BEEF, 0);
        access("half_lds",  0, 2'd1, 0, 32'h12,  32'h0,        1, 32'h8001_7FFF, 0);
        access("half_ldu",  0, 2'd1, 1, 32'h12,  32'h0,        0, 32'h8001_7FFF, 0);
        access("byte_lds",  0, 2'd2, 0, 32'h40,  32'h0,        0, 32'h0000_0080, 0);
        access("word_st_m", 1, 2'd0, 0, 32'h102, 32'h1234_5678, 0, 32'h0,         0);
        access("half_ld_m", 0, 2'd1, 0, 32'h101, 32'h0,        0, 32'h0,         0);
        access("timeout",   0, 2'd0, 0, 32'h300, 32'h0,       -1, 32'h0,         0);
        access("ack_err",   0, 2'd0, 0, 32'h304, 32'h0,        1, 32'h1111_2222, 1);
        access("w3_store",  1, 2'd3, 0, 32'h308, 32'hCAFE_F00D, 3, 32'h0,         0);
        access("half_st_hi",1, 2'd1, 0, 32'h30E, 32'h0000_BEEF, 0, 32'h0,         0);
        access("ack_last",  0, 2'd2, 1, 32'h311, 32'h0,  TO - 1, 32'h0000_9900, 0);

        // Reset while in REQ: bus released next cycle, late ack ignored
        cur = "rst_in_req";
        @(posedge clk); #1;
        M_Req = 1'b1; M_WE = 1'b0; M_Width = 2'd0; M_Addr = 32'h400;
        @(posedge clk); #1;
        @(posedge clk); #1;
        reset = 1'b0; M_Req = 1'b0;
        @(posedge clk); #1;
        @(negedge clk);
        chk("req", 32'(bus_req), 32'd0);
        chk("stall", 32'(M_Stall), 32'd0);
        @(posedge clk); #1;
        reset = 1'b1; bus_ack = 1'b1; bus_rd = 32'h5555_AAAA;
        @(posedge clk); #1;
        bus_ack = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("late_ack_done", 32'(M_Done), 32'd0);
            chk("late_ack_req", 32'(bus_req), 32'd0);
            @(posedge clk); #1;
        end
        $display("txn rst_in_req late ack ignored");

        // Randomized accesses
        for (int k = 0; k < 40; k++) begin
            logic [31:0] ra;
            int          ack;
            ra  = {20'd0, 12'($urandom)};
            ack = ($urandom_range(0, 9) == 0) ? -1 : int'($urandom_range(0, 5));
            access($sformatf("rnd%0d", k), 1'($urandom), 2'($urandom), 1'($urandom), ra,
                   $urandom, ack, $urandom, ($urandom_range(0, 7) == 0));
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
